// File: rtl/seq_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ser_pkg
//  Brief    : Shared constants and FSM encoding for the word serializer.
//  Revision : 1.0  initial release
// ============================================================================
package seq_ser_pkg;

    localparam int C_DEFAULT_WIDTH = 8;
    localparam int C_CNT_W         = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_serializer_if
//  Brief    : Parallel-in / serial-out bus bundle for the word serializer.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_serializer_if #(
    parameter int WIDTH = seq_ser_pkg::C_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic [7:0]       words_sent;

    modport master (
        output in_data, in_valid,
        input  in_ready, x, x_valid, busy, words_sent
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, x, x_valid, busy, words_sent
    );
endinterface
`default_nettype wire

// File: rtl/seq_ser_buf.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ser_buf
//  Brief    : One-entry holding buffer (data + full flag) with load/take.
//  Revision : 1.0  initial release
// ============================================================================
module seq_ser_buf #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             take,
    input  wire logic [WIDTH-1:0] load_data,
    output logic      [WIDTH-1:0] data,
    output logic                  full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (load) begin
            r_data <= load_data;
            r_full <= 1'b1;
        end else if (take) begin
            r_full <= 1'b0;
        end
    end

    assign data = r_data;
    assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : seq_serializer
//  Brief    : Serializes parallel words onto a 1-bit stream, one-word buffer.
//  Revision : 1.0  initial release
// ============================================================================
module seq_serializer
    import seq_ser_pkg::*;
#(
    parameter int WIDTH     = C_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    seq_serializer_if.slave bus
);

    localparam logic [C_CNT_W-1:0] LAST_CNT = C_CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic [C_CNT_W-1:0]   r_bit_cnt;
    logic                 r_x;
    logic                 r_x_valid;
    logic                 r_busy;
    logic [7:0]           r_words_sent;

    logic                 w_buf_full;
    logic [WIDTH-1:0]     w_buf_data;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_do_load;
    logic                 w_take;
    logic                 w_buf_load;
    logic [WIDTH-1:0]     w_load_word;
    logic [WIDTH-1:0]     w_src;
    logic                 w_src_bit;
    logic [WIDTH-1:0]     w_src_rest;
    state_t               w_state_nxt;
    logic                 w_full_nxt;

    assign w_in_ready = ~w_buf_full & ~reset;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_last     = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_CNT);

    // A word offered at the last-bit edge with an empty buffer goes straight
    // into the shifter, so a continuous producer never sees an idle gap.
    always_comb begin
        w_do_load   = 1'b0;
        w_take      = 1'b0;
        w_buf_load  = 1'b0;
        w_load_word = bus.in_data;
        if (r_state == ST_IDLE) begin
            w_do_load = w_accept;
        end else if (w_last) begin
            if (w_buf_full) begin
                w_do_load   = 1'b1;
                w_take      = 1'b1;
                w_load_word = w_buf_data;
            end else begin
                w_do_load = w_accept;
            end
        end else begin
            w_buf_load = w_accept;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_do_load) begin
            w_state_nxt = ST_SHIFT;
        end else if (w_last) begin
            w_state_nxt = ST_IDLE;
        end
        w_full_nxt = w_take ? 1'b0 : (w_buf_load ? 1'b1 : w_buf_full);
    end

    assign w_src = w_do_load ? w_load_word : r_shreg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_src_bit  = w_src[WIDTH-1];
            assign w_src_rest = {w_src[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_src_bit  = w_src[0];
            assign w_src_rest = {1'b0, w_src[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_x          <= 1'b0;
            r_x_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_words_sent <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_SHIFT) || w_full_nxt;
            if (w_last) begin
                r_words_sent <= r_words_sent + 8'd1;
            end
            if (w_do_load) begin
                r_shreg   <= w_src_rest;
                r_x       <= w_src_bit;
                r_x_valid <= 1'b1;
                r_bit_cnt <= '0;
            end else if (w_last) begin
                r_x       <= 1'b0;
                r_x_valid <= 1'b0;
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shreg   <= w_src_rest;
                r_x       <= w_src_bit;
                r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
            end
        end
    end

    seq_ser_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (w_buf_load),
        .take      (w_take),
        .load_data (bus.in_data),
        .data      (w_buf_data),
        .full      (w_buf_full)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.x          = r_x;
    assign bus.x_valid    = r_x_valid;
    assign bus.busy       = r_busy;
    assign bus.words_sent = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_serializer
//  Brief    : Directed self-checking bench for seq_serializer (MSB and LSB).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_serializer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [4:0] det_sr;
    logic       det_hit;

    seq_serializer_if #(.WIDTH(8)) bus  ();
    seq_serializer_if #(.WIDTH(8)) bus2 ();

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 11001 detector watching the MSB-first stream
    initial begin
        det_sr  = 5'b0;
        det_hit = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.x_valid === 1'b1) begin
            det_sr = {det_sr[3:0], bus.x};
            if (det_sr == 5'b11001) det_hit = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // emit holds the expected stream with the first emitted bit in bit 7
    task automatic expect_bits(input string tag, input logic [7:0] emit,
                               input int first, input bit use_b);
        for (int i = first; i < 8; i++) begin
            chk({tag, "_xv"}, use_b ? bus2.x_valid : bus.x_valid, 32'd1);
            chk({tag, "_x"},  use_b ? bus2.x       : bus.x,       32'(emit[7-i]));
            tick();
        end
    endtask

    initial begin
        int acc;
        int cyc;
        int max_ws;

        checks = 0;
        errors = 0;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus2.in_data  = 8'h00;
        bus2.in_valid = 1'b0;
        reset = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_x",        bus.x,          32'd0);
        chk("rst_xvalid",   bus.x_valid,    32'd0);
        chk("rst_in_ready", bus.in_ready,   32'd0);
        chk("rst_busy",     bus.busy,       32'd0);
        chk("rst_words",    bus.words_sent, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", bus.in_ready, 32'd1);

        // Single word C8
        bus.in_data  = 8'hC8;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("single_busy", bus.busy, 32'd1);
        expect_bits("single", 8'hC8, 0, 1'b0);
        chk("single_xv_end", bus.x_valid,    32'd0);
        chk("single_x_end",  bus.x,          32'd0);
        chk("single_words",  bus.words_sent, 32'd1);
        chk("single_idle",   bus.busy,       32'd0);
        chk("detector_hit",  det_hit,        32'd1);

        // Back-to-back C8 then 19
        bus.in_data  = 8'hC8;
        bus.in_valid = 1'b1;
        tick();
        chk("b2b_ready0", bus.in_ready, 32'd1);
        chk("b2b_x0",     bus.x,        32'd1);
        bus.in_data = 8'h19;
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_buf_full", bus.in_ready, 32'd0);
        expect_bits("b2b_w1", 8'hC8, 1, 1'b0);
        expect_bits("b2b_w2", 8'h19, 0, 1'b0);
        chk("b2b_xv_end", bus.x_valid,    32'd0);
        chk("b2b_words",  bus.words_sent, 32'd3);

        // Back-pressure: A5, 3C, F0 offered continuously
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        tick();
        chk("bp_x0", bus.x, 32'd1);
        bus.in_data = 8'h3C;
        tick();
        bus.in_data = 8'h77;
        for (int i = 1; i < 8; i++) begin
            chk("bp_w1_x",     bus.x,        32'((8'hA5 >> (7 - i)) & 8'h01));
            chk("bp_stall",    bus.in_ready, 32'd0);
            tick();
        end
        chk("bp_ready_rise", bus.in_ready, 32'd1);
        chk("bp_w2_xv0",     bus.x_valid,  32'd1);
        chk("bp_w2_x0",      bus.x,        32'd0);
        bus.in_data = 8'hF0;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_w3_buffered", bus.in_ready, 32'd0);
        expect_bits("bp_w2", 8'h3C, 1, 1'b0);
        expect_bits("bp_w3", 8'hF0, 0, 1'b0);
        chk("bp_xv_end", bus.x_valid,    32'd0);
        chk("bp_words",  bus.words_sent, 32'd6);

        // Reset after three bits of FF, with a second word buffered
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            chk("rmw_xv", bus.x_valid, 32'd1);
            chk("rmw_x",  bus.x,       32'd1);
            tick();
            bus.in_valid = 1'b0;
        end
        reset = 1'b1;
        tick();
        chk("rmw_xv_off", bus.x_valid,    32'd0);
        chk("rmw_x_off",  bus.x,          32'd0);
        chk("rmw_words",  bus.words_sent, 32'd0);
        chk("rmw_busy",   bus.busy,       32'd0);
        chk("rmw_ready",  bus.in_ready,   32'd0);
        reset = 1'b0;
        #1;
        chk("rmw_ready_back", bus.in_ready, 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("rmw_quiet", bus.x_valid, 32'd0);
            tick();
        end

        // 256 words, counter wraps to zero
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        acc    = 0;
        cyc    = 0;
        max_ws = 0;
        while (acc < 256 && cyc < 5000) begin
            if (bus.in_ready) acc++;
            tick();
            cyc++;
            if (acc == 256) bus.in_valid = 1'b0;
            if (int'(bus.words_sent) > max_ws) max_ws = int'(bus.words_sent);
        end
        bus.in_valid = 1'b0;
        chk("wrap_accept_budget", 32'(acc), 32'd256);
        while (bus.busy && cyc < 5000) begin
            tick();
            cyc++;
            if (int'(bus.words_sent) > max_ws) max_ws = int'(bus.words_sent);
        end
        chk("wrap_drain_budget", 32'(bus.busy), 32'd0);
        chk("wrap_max",   32'(max_ws),    32'd255);
        chk("wrap_words", bus.words_sent, 32'd0);

        // LSB-first instance: 13 emits 1,1,0,0,1,0,0,0
        bus2.in_data  = 8'h13;
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        expect_bits("lsb", 8'b1100_1000, 0, 1'b1);
        chk("lsb_xv_end", bus2.x_valid,    32'd0);
        chk("lsb_words",  bus2.words_sent, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
